// File: rtl/seq_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------
// seq_pkg: run-state encoding and default widths for prog_sequencer
// Rev 1.0
// ---------------------------------------------------------------------
package seq_pkg;

  localparam int PC_WIDTH_D  = 11;
  localparam int CNT_WIDTH_D = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/pc_next_calc.sv
`default_nettype none
// ---------------------------------------------------------------------
// pc_next_calc: next-PC select for stall / absolute / relative / step
// Rev 1.0
// ---------------------------------------------------------------------
module pc_next_calc
  import seq_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_D
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                stall,
  input  logic                branch_en,
  input  logic                branch_rel,
  input  logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc_next
);

  // Both the relative add and the step wrap naturally at 2**PC_WIDTH.
  always_comb begin
    pc_next = pc + 1'b1;
    if (stall) begin
      pc_next = pc;
    end else if (branch_en) begin
      pc_next = branch_rel ? (pc + target) : target;
    end
  end

endmodule
`default_nettype wire

// File: rtl/prog_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------
// prog_sequencer: PC owner with IDLE/RUN/DONE run control; option WATCHDOG_EN
// Rev 1.0
// ---------------------------------------------------------------------
module prog_sequencer
  import seq_pkg::*;
#(
  parameter int                  PC_WIDTH    = PC_WIDTH_D,
  parameter logic [PC_WIDTH-1:0] START_PC    = '0,
  parameter logic [PC_WIDTH:0]   HALT_PC     = (PC_WIDTH+1)'(78),
  parameter int                  CNT_WIDTH   = CNT_WIDTH_D,
  parameter int                  WDOG_CYCLES = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 halt,
  input  logic                 branch_en,
  input  logic                 branch_rel,
  input  logic [PC_WIDTH-1:0]  target,
  output logic [PC_WIDTH-1:0]  pc,
  output logic                 running,
  output logic                 done,
  output logic                 timeout,
  output logic [CNT_WIDTH-1:0] cycle_count
);

`ifdef WATCHDOG_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif
  localparam logic [CNT_WIDTH-1:0] WDOG_LAST = CNT_WIDTH'(WDOG_CYCLES - 1);

  seq_state_t           state, state_nx;
  logic [PC_WIDTH-1:0]  pc_nx, pc_step;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic                 timeout_q, timeout_nx;
  logic                 addr_halt, wdog_hit;

  pc_next_calc #(
    .PC_WIDTH (PC_WIDTH)
  ) u_pc_next (
    .pc         (pc),
    .stall      (stall),
    .branch_en  (branch_en),
    .branch_rel (branch_rel),
    .target     (target),
    .pc_next    (pc_step)
  );

  // HALT_PC is one bit wider so 2**PC_WIDTH can never be reached.
  assign addr_halt = ({1'b0, pc} >= HALT_PC);
  assign wdog_hit  = WDOG_EN && (cycle_count == WDOG_LAST);

  always_comb begin
    state_nx   = state;
    pc_nx      = pc;
    cnt_nx     = cycle_count;
    timeout_nx = timeout_q;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nx   = RUN;
          pc_nx      = START_PC;
          cnt_nx     = '0;
          timeout_nx = 1'b0;
        end
      end
      RUN: begin
        if (cycle_count != {CNT_WIDTH{1'b1}}) begin
          cnt_nx = cycle_count + 1'b1;
        end
        if (addr_halt || halt) begin
          state_nx = DONE;
        end else if (wdog_hit) begin
          state_nx   = DONE;
          timeout_nx = 1'b1;
        end else begin
          pc_nx = pc_step;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      pc          <= START_PC;
      cycle_count <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_nx;
      pc          <= pc_nx;
      cycle_count <= cnt_nx;
      timeout_q   <= timeout_nx;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);
  assign timeout = timeout_q;

endmodule
`default_nettype wire

// File: doc/prog_sequencer.md
Name: prog_sequencer

Overview:
- Parametrised program-counter sequencer with run control for the accumulator core; it supersedes the fixed start/done/PC logic in the current core.
- Owns the PC and the IDLE/RUN/DONE run state machine, including the start/done handshake.
- Applies branches in absolute or PC-relative mode, honours stall and halt, and counts run cycles.
- Drives the instruction ROM address; control and branch LUT feed branch requests.

Parameters:
- PC_WIDTH, 11, PC and branch target width.
- START_PC, 0, PC loaded on each start.
- HALT_PC, 78, PC value at or above which the run ends; width PC_WIDTH+1; 2**PC_WIDTH disables the address halt.
- CNT_WIDTH, 16, cycle counter width.
- WDOG_CYCLES, 4096, watchdog limit (used only with WATCHDOG_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE.
- stall  in  1  freezes PC this cycle.
- halt  in  1  halt instruction decoded this cycle.
- branch_en  in  1  branch taken this cycle.
- branch_rel  in  1  1 = relative (pc + target), 0 = absolute (target).
- target  in  PC_WIDTH  branch target; two's complement offset when branch_rel=1.
- pc  out  PC_WIDTH  instruction address.
- running  out  1  high in RUN.
- done  out  1  high in DONE; held until next start.
- timeout  out  1  run ended by watchdog.
- cycle_count  out  CNT_WIDTH  cycles spent in RUN for the current or last run.

Behaviour:
- Reset (reset=0, immediate, asynchronous):
  - state=IDLE, pc=START_PC, done=0, running=0, timeout=0, cycle_count=0.
  - Applies mid-run with no drain.
- IDLE: start=1 -> RUN next edge; pc=START_PC, cycle_count=0. Other inputs ignored.
- RUN: evaluated per rising edge, first match wins:
  1. pc >= HALT_PC, or halt=1 -> DONE; pc holds.
  2. stall=1 -> pc holds.
  3. branch_en=1, branch_rel=0 -> pc=target.
  4. branch_en=1, branch_rel=1 -> pc=pc+target, modulo 2**PC_WIDTH.
  5. Otherwise -> pc=pc+1; wraps 2**PC_WIDTH-1 -> 0.
- cycle_count increments on every edge spent in RUN, including stall and the exiting edge; it saturates at all-ones.
- start while in RUN is ignored.
- DONE:
  - done=1, running=0; pc and cycle_count frozen.
  - start=1 -> RUN; loads START_PC, clears cycle_count, done and timeout.
- Outputs are registered or decoded from state only; there is no combinational input-to-output path.
- start and reset edge coincident: reset wins.

Optional Feature:
- Macro WATCHDOG_EN.
- Defined: in RUN, when cycle_count == WDOG_CYCLES-1 at an edge and no higher-priority exit applies, go to DONE with timeout=1. A halt or address exit on the same edge takes precedence and gives timeout=0.
- Undefined: timeout tied 0; WDOG_CYCLES unused.

Decomposition:
- Package seq_pkg holds:
  - state enum seq_state_t {IDLE, RUN, DONE}, 2 bits.
  - default width constants PC_WIDTH_D=11, CNT_WIDTH_D=16.
- One combinational sub-module, pc_next_calc: computes the next PC from pc, stall, branch_en, branch_rel and target. The wrap arithmetic lives there.
- FSM, counter and watchdog stay in prog_sequencer.

Test Plan:
- Basic run: reset, then start pulse with defaults and no branches -> running=1, pc counts 0..78. On the edge after pc=78 appears: done=1, running=0, cycle_count=79, pc holds at 78.
- Absolute branch: at pc=10, branch_en=1, branch_rel=0, target=5 -> next pc=5. Relative branch: target=11'h7FD (-3) at pc=10 -> next pc=7.
- Wrap: HALT_PC=2048, absolute branch to 2047, then one cycle with no branch -> pc=0. Same setup, relative +2 from 2047 -> pc=1.
- Stall and halt: stall 3 cycles at pc=20 -> pc stays 20 and cycle_count rises by 3. Then halt=1 with branch_en=1 -> DONE, pc=20.
- Reset and restart: assert reset asynchronously mid-run at pc=40 -> immediately pc=0, running=0, done=0. Start in DONE -> pc=START_PC, cycle_count=0. Start during RUN -> no effect.
- Watchdog (WATCHDOG_EN, WDOG_CYCLES=16): loop with absolute branch to 3 each cycle -> after 16 RUN cycles done=1, timeout=1. Rebuild without the macro -> loop never ends and timeout stays 0.
